// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
module div_unit #(
   parameter int XLEN      = 32,
   parameter int REG_WIDTH = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wb_do_branch,
   input  logic                 ix_div_valid,
   input  logic [1:0]           ix_div_control,
   input  logic [REG_WIDTH-1:0] ix_div_rd,
   input  logic [XLEN-1:0]      ix_div_rs1,
   input  logic [XLEN-1:0]      ix_div_rs2,
   output logic                 div_wb_valid,
   input  logic                 div_wb_ready,
   output logic                 div_wb_wr_en,
   output logic [REG_WIDTH-1:0] div_wb_rd,
   output logic [XLEN-1:0]      div_wb_data,
   output logic                 div_ix_done,
   output logic                 div_busy
);
   typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;
   state_t state;
   logic [XLEN-1:0] q, r, d, a1, a2, qf, rf;
   logic [XLEN:0] sh, diff;
   logic [5:0] cnt;
   logic [1:0] ctrl;
   logic sign_q, sign_r, is_signed, s1, s2, ovf;
   always_comb begin
      is_signed = !ix_div_control[0];
      s1 = is_signed && ix_div_rs1[XLEN-1];
      s2 = is_signed && ix_div_rs2[XLEN-1];
      a1 = s1 ? -ix_div_rs1 : ix_div_rs1;
      a2 = s2 ? -ix_div_rs2 : ix_div_rs2;
      ovf = is_signed && ix_div_rs1 == {1'b1, {(XLEN-1){1'b0}}} && ix_div_rs2 == '1;
      sh = {r, q[XLEN-1]};
      diff = sh - {1'b0, d};
      qf = (!ctrl[0] && sign_q) ? -q : q;
      rf = (!ctrl[0] && sign_r) ? -r : r;
   end
   assign div_busy     = state != IDLE;
   assign div_wb_valid = state == DONE;
   assign div_wb_wr_en = div_wb_valid && div_wb_rd != '0;
   assign div_ix_done  = div_wb_valid && div_wb_ready && !wb_do_branch;
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         div_wb_rd <= '0;
         div_wb_data <= '0;
         q <= '0;
         r <= '0;
         d <= '0;
         cnt <= '0;
         ctrl <= '0;
         sign_q <= 1'b0;
         sign_r <= 1'b0;
      end else if (wb_do_branch) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: if (ix_div_valid) begin
               ctrl <= ix_div_control;
               div_wb_rd <= ix_div_rd;
               sign_q <= s1 ^ s2;
               sign_r <= s1;
               q <= a1;
               d <= a2;
               r <= '0;
               cnt <= '0;
               // divide-by-zero and signed overflow bypass the iteration entirely
               if (ix_div_rs2 == '0) begin
                  div_wb_data <= ix_div_control[1] ? ix_div_rs1 : '1;
                  state <= DONE;
               end else if (ovf) begin
                  div_wb_data <= ix_div_control[1] ? '0 : ix_div_rs1;
                  state <= DONE;
               end else begin
                  state <= CALC;
               end
            end
            CALC: begin
               r <= diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0];
               q <= {q[XLEN-2:0], !diff[XLEN]};
               cnt <= cnt + 6'd1;
               if (cnt == 6'(XLEN-1)) state <= FIXUP;
            end
            FIXUP: begin
               div_wb_data <= ctrl[1] ? rf : qf;
               state <= DONE;
            end
            DONE: if (div_wb_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
